frame_capture_ctrl: RTL and testbench

//  Consumes the 1 s request_new_frame pulse and captures exactly one CMOS frame per request.

---
 rtl/frame_capture_ctrl_pkg.sv | 35 +++
 rtl/frame_capture_ctrl_pix_pack8to16.sv | 64 ++++++
 rtl/frame_capture_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_capture_ctrl_pkg.sv
// Shared FSM encodings, frame_err codes and sensor defaults
// for the CMOS frame capture controller.
package frame_capture_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_WAIT_FS = 2'b01,
        S_CAPTURE = 2'b10,
        S_DONE    = 2'b11
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_TMO  = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;
    localparam logic [1:0] ERR_SIZE = 2'b11;

    localparam int DEF_H_ACT   = 1280;
    localparam int DEF_V_ACT   = 1024;
    localparam int DEF_TMO_CYC = 2000000;

    function automatic logic rise(
        input logic cur,
        input logic prev
    );
        return cur & ~prev;
    endfunction

    function automatic logic fall(
        input logic cur,
        input logic prev
    );
        return ~cur & prev;
    endfunction

endpackage

// File: rtl/frame_capture_ctrl_pix_pack8to16.sv
// pix_pack8to16: packs pairs of 8-bit pixels into 16-bit words.
// Ports: clk, rst_n, en, clr, pix_vld, pix_data, block -> due, wr_en, din.
module pix_pack8to16
    import frame_capture_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic        pix_vld,
    input  logic [7:0]  pix_data,
    input  logic        block,
    output logic        due,
    output logic        wr_en,
    output logic [15:0] din
);

    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic        wr_q, wr_d;
    logic [15:0] din_q, din_d;

    // A word is due whenever the second pixel of a pair arrives.
    assign due = en & ~clr & pix_vld & phase_q;

    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        wr_d    = 1'b0;
        din_d   = din_q;
        if (clr || !en) begin
            phase_d = 1'b0;
        end else if (pix_vld) begin
            if (!phase_q) begin
                hi_d    = pix_data;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (!block) begin
                    wr_d  = 1'b1;
                    din_d = {hi_q, pix_data};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            hi_q    <= 8'h00;
            wr_q    <= 1'b0;
            din_q   <= 16'h0000;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
            wr_q    <= wr_d;
            din_q   <= din_d;
        end
    end

    assign wr_en = wr_q;
    assign din   = din_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Captures one CMOS frame per request into the DDR3 write FIFO.
// Ports: clk, rst_n, initial_done, request_new_frame, cmos_fval,
//   cmos_lval, cmos_data, fifo_full -> fifo_wr_en, fifo_din,
//   frame_busy, frame_done, frame_err (+ drop_cnt when
//   FRAME_DROP_CNT_EN is defined).
module frame_capture_ctrl
    import frame_capture_ctrl_pkg::*;
#(
    parameter int H_ACT   = DEF_H_ACT,
    parameter int V_ACT   = DEF_V_ACT,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        initial_done,
    input  logic        request_new_frame,
    input  logic        cmos_fval,
    input  logic        cmos_lval,
    input  logic [7:0]  cmos_data,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_din,
    output logic        frame_busy,
    output logic        frame_done,
    output logic [1:0]  frame_err
`ifdef FRAME_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    // One extra code point so over-long lines/frames are visible.
    localparam int PW = $clog2(H_ACT + 1);
    localparam int LW = $clog2(V_ACT + 1);
    localparam int TW = $clog2(TMO_CYC);

    state_e state_q, state_d;
    logic [1:0]    err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [LW-1:0] line_q, line_d;
    logic          bad_q, bad_d;

    logic       fval_q, fval_p_q;
    logic       lval_q, lval_p_q;
    logic [7:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fval_q   <= 1'b0;
            fval_p_q <= 1'b0;
            lval_q   <= 1'b0;
            lval_p_q <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            fval_q   <= cmos_fval;
            fval_p_q <= fval_q;
            lval_q   <= cmos_lval;
            lval_p_q <= lval_q;
            data_q   <= cmos_data;
        end
    end

    logic fval_rise, fval_fall, lval_fall;
    assign fval_rise = rise(fval_q, fval_p_q);
    assign fval_fall = fall(fval_q, fval_p_q);
    assign lval_fall = fall(lval_q, lval_p_q);

    logic cap_en, pk_clr, pk_due, pk_wr;
    assign cap_en = (state_q == S_CAPTURE) & initial_done;
    assign pk_clr = lval_fall;

    pix_pack8to16 u_pack (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (cap_en),
        .clr      (pk_clr),
        .pix_vld  (lval_q),
        .pix_data (data_q),
        .block    (fifo_full),
        .due      (pk_due),
        .wr_en    (pk_wr),
        .din      (fifo_din)
    );

    logic ovf;
    assign ovf = pk_due & fifo_full;

    // Final size verdict folds in a line ending on the same
    // cycle as the frame.
    logic [LW:0] line_fin;
    logic        bad_fin;
    logic        size_ok;
    assign line_fin = {1'b0, line_q} + (LW+1)'(lval_fall);
    assign bad_fin  = bad_q
                    | (lval_fall & (pix_q != PW'(H_ACT)));
    assign size_ok  = !bad_fin
                    && (line_fin == (LW+1)'(V_ACT));

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        pix_d   = pix_q;
        line_d  = line_q;
        bad_d   = bad_q;
        if (!initial_done) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (request_new_frame) begin
                        err_d   = ERR_NONE;
                        tmo_d   = '0;
                        state_d = S_WAIT_FS;
                    end
                end
                S_WAIT_FS: begin
                    pix_d  = '0;
                    line_d = '0;
                    bad_d  = 1'b0;
                    if (fval_rise) begin
                        state_d = S_CAPTURE;
                    end else if (tmo_q == TW'(TMO_CYC - 1)) begin
                        err_d   = ERR_TMO;
                        state_d = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (ovf) begin
                        err_d   = ERR_OVF;
                        state_d = S_IDLE;
                    end else if (fval_fall) begin
                        if (size_ok) begin
                            state_d = S_DONE;
                        end else begin
                            err_d   = ERR_SIZE;
                            state_d = S_IDLE;
                        end
                    end else begin
                        if (lval_q) begin
                            if (pix_q == PW'(H_ACT)) begin
                                bad_d = 1'b1;
                            end else begin
                                pix_d = pix_q + 1'b1;
                            end
                        end
                        if (lval_fall) begin
                            pix_d = '0;
                            if (pix_q != PW'(H_ACT)) begin
                                bad_d = 1'b1;
                            end
                            if (line_q == LW'(V_ACT)) begin
                                bad_d = 1'b1;
                            end else begin
                                line_d = line_q + 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            err_q   <= ERR_NONE;
            tmo_q   <= '0;
            pix_q   <= '0;
            line_q  <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            bad_q   <= bad_d;
        end
    end

    // A pending word is dropped the moment init is withdrawn.
    assign fifo_wr_en = pk_wr & initial_done;
    assign frame_busy = (state_q == S_WAIT_FS)
                      | (state_q == S_CAPTURE);
    assign frame_done = (state_q == S_DONE) & initial_done;
    assign frame_err  = err_q;

`ifdef FRAME_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (request_new_frame && (state_q != S_IDLE)
            && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 16'h0000;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl.
// Small geometry: 4 pixels x 2 lines, 50-cycle timeout.
module tb_frame_capture_ctrl;

    localparam int H = 4;
    localparam int V = 2;
    localparam int T = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        initial_done = 1'b0;
    logic        req = 1'b0;
    logic        fval = 1'b0;
    logic        lval = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        full = 1'b0;
    logic        fifo_wr_en;
    logic [15:0] fifo_din;
    logic        frame_busy;
    logic        frame_done;
    logic [1:0]  frame_err;
`ifdef FRAME_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    frame_capture_ctrl #(
        .H_ACT   (H),
        .V_ACT   (V),
        .TMO_CYC (T)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .initial_done      (initial_done),
        .request_new_frame (req),
        .cmos_fval         (fval),
        .cmos_lval         (lval),
        .cmos_data         (data),
        .fifo_full         (full),
        .fifo_wr_en        (fifo_wr_en),
        .fifo_din          (fifo_din),
        .frame_busy        (frame_busy),
        .frame_done        (frame_done),
        .frame_err         (frame_err)
`ifdef FRAME_DROP_CNT_EN
        ,
        .drop_cnt          (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] wq[$];
    int          done_tot = 0;

    always @(negedge clk) begin
        if (fifo_wr_en) wq.push_back(fifo_din);
        if (frame_done) done_tot++;
    end

    typedef struct {
        int         lines;
        int         pix;
        int         full_line;
        bit         skip;
        int         rpl;
        int         exp_wr;
        logic [1:0] exp_err;
        int         exp_done;
    } vec_t;

    vec_t tv[8];
    int   nvec = 0;
    int   nerr = 0;
    int   exp_drop = 0;
    int   pix_val = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input int act,
                       input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h",
                     nm, act, exp);
        end
    endtask

    task automatic do_req();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic line_out(input int pix, input int rpl);
        for (int p = 0; p < pix; p++) begin
            lval = 1'b1;
            data = pix_val[7:0];
            pix_val++;
            req = (p == 0) && (rpl > 0);
            tick();
            req = 1'b0;
        end
        lval = 1'b0;
        data = 8'h00;
        tick();
        tick();
    endtask

    task automatic run_vec(input int i);
        int wbase;
        int dbase;
        int base;
        int n;
        logic [15:0] ew;
        wbase = wq.size();
        dbase = done_tot;
        base = 1 + 16 * i;
        if (tv[i].skip) begin
            fval = 1'b1;
            tick();
            tick();
            do_req();
            pix_val = 8'hA0;
            line_out(H, 0);
            fval = 1'b0;
            tick();
            tick();
        end else begin
            do_req();
        end
        chk($sformatf("v%0d busy_after_req", i),
            int'(frame_busy), 1);
        chk($sformatf("v%0d err_cleared", i),
            int'(frame_err), 0);
        pix_val = base;
        fval = 1'b1;
        tick();
        tick();
        for (int l = 0; l < tv[i].lines; l++) begin
            if (tv[i].full_line != 0 && l + 1 >= tv[i].full_line)
                full = 1'b1;
            line_out(tv[i].pix, tv[i].rpl);
        end
        fval = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        full = 1'b0;
        exp_drop += tv[i].lines * tv[i].rpl;
        n = wq.size() - wbase;
        chk($sformatf("v%0d writes", i), n, tv[i].exp_wr);
        for (int k = 0; k < n && k < tv[i].exp_wr; k++) begin
            ew = {8'(base + 2 * k), 8'(base + 2 * k + 1)};
            chk($sformatf("v%0d word%0d", i, k),
                int'(wq[wbase + k]), int'(ew));
        end
        chk($sformatf("v%0d err", i),
            int'(frame_err), int'(tv[i].exp_err));
        chk($sformatf("v%0d done", i),
            done_tot - dbase, tv[i].exp_done);
        chk($sformatf("v%0d busy_end", i),
            int'(frame_busy), 0);
    endtask

    initial begin
        int wb;
        int db;
        //        lines pix full skip rpl wr err done
        tv[0] = '{2, 4, 0, 1'b0, 0, 4, 2'b00, 1};
        tv[1] = '{2, 4, 0, 1'b1, 0, 4, 2'b00, 1};
        tv[2] = '{2, 4, 2, 1'b0, 0, 2, 2'b10, 0};
        tv[3] = '{2, 4, 0, 1'b0, 0, 4, 2'b00, 1};
        tv[4] = '{3, 4, 0, 1'b0, 1, 6, 2'b11, 0};
        tv[5] = '{2, 6, 0, 1'b0, 0, 6, 2'b11, 0};
        tv[6] = '{1, 4, 0, 1'b0, 0, 2, 2'b11, 0};
        tv[7] = '{2, 4, 0, 1'b0, 0, 4, 2'b00, 1};

        tick();
        tick();
        chk("rst wr_en", int'(fifo_wr_en), 0);
        chk("rst din", int'(fifo_din), 0);
        chk("rst busy", int'(frame_busy), 0);
        chk("rst done", int'(frame_done), 0);
        chk("rst err", int'(frame_err), 0);
        rst_n = 1'b1;
        tick();

        do_req();
        chk("no_init busy", int'(frame_busy), 0);
        initial_done = 1'b1;
        tick();

        wb = wq.size();
        db = done_tot;
        do_req();
        for (int c = 1; c < T; c++) tick();
        chk("tmo busy_before", int'(frame_busy), 1);
        chk("tmo err_before", int'(frame_err), 0);
        tick();
        chk("tmo busy_after", int'(frame_busy), 0);
        chk("tmo err", int'(frame_err), 1);
        chk("tmo writes", wq.size() - wb, 0);
        chk("tmo done", done_tot - db, 0);

        for (int i = 0; i < 7; i++) begin
            run_vec(i);
`ifdef FRAME_DROP_CNT_EN
            chk($sformatf("v%0d drop_cnt", i),
                int'(drop_cnt), exp_drop);
`endif
        end

        wb = wq.size();
        do_req();
        fval = 1'b1;
        tick();
        tick();
        pix_val = 8'h50;
        line_out(H, 0);
        initial_done = 1'b0;
        #1;
        chk("idrop wr_en", int'(fifo_wr_en), 0);
        tick();
        chk("idrop busy", int'(frame_busy), 0);
        chk("idrop err", int'(frame_err), 0);
        chk("idrop writes", wq.size() - wb, 2);
        initial_done = 1'b1;
        fval = 1'b0;
        tick();
        tick();
        tick();

        do_req();
        fval = 1'b1;
        tick();
        tick();
        pix_val = 8'h60;
        for (int p = 0; p < 3; p++) begin
            lval = 1'b1;
            data = pix_val[7:0];
            pix_val++;
            tick();
        end
        chk("pre_rst wr_en", int'(fifo_wr_en), 1);
        chk("pre_rst busy", int'(frame_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst wr_en", int'(fifo_wr_en), 0);
        chk("arst din", int'(fifo_din), 0);
        chk("arst busy", int'(frame_busy), 0);
        chk("arst err", int'(frame_err), 0);
        lval = 1'b0;
        fval = 1'b0;
        data = 8'h00;
        tick();
        rst_n = 1'b1;
        exp_drop = 0;
        tick();
        run_vec(7);
`ifdef FRAME_DROP_CNT_EN
        chk("post_rst drop_cnt", int'(drop_cnt), exp_drop);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
